// File: rtl/ip_dram_pkg.sv
// Shared definitions for the ip_sdram user-port arbiter: bus widths and arbiter state encoding.
package ip_dram_pkg;

  localparam int DRAM_AW = 27;
  localparam int DRAM_DW = 128;
  localparam int DRAM_MW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    REFRESH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ip_dram_tag_fifo.sv
// Read-tag FIFO: remembers which requester issued each outstanding read so returns can be routed in order.
module ip_dram_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A push into a full FIFO is only honoured when a pop frees a slot in the same cycle
  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);

  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == '0);
  assign head  = mem_r[rd_ptr_r];

  // Storage and pointer/occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_r    <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_tag;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ip_dram_arbiter.sv
// Two-requester round-robin arbiter in front of the ip_sdram user port, with in-order read-return
// routing and refresh_req/refresh_ack sequencing.
module ip_dram_arbiter
  import ip_dram_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_AW          = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DRAM_AW-1:0] s0_address,
  input  logic               s0_write,
  input  logic               s0_valid,
  output logic               s0_ready,
  input  logic [DRAM_DW-1:0] s0_wdata,
  input  logic [DRAM_MW-1:0] s0_wdata_mask,
  output logic [DRAM_DW-1:0] s0_rdata,
  output logic               s0_rdata_valid,
  input  logic [DRAM_AW-1:0] s1_address,
  input  logic               s1_write,
  input  logic               s1_valid,
  output logic               s1_ready,
  input  logic [DRAM_DW-1:0] s1_wdata,
  input  logic [DRAM_MW-1:0] s1_wdata_mask,
  output logic [DRAM_DW-1:0] s1_rdata,
  output logic               s1_rdata_valid,
  output logic [DRAM_AW-1:0] dram_address,
  output logic               dram_write,
  output logic               dram_valid,
  input  logic               dram_ready,
  output logic [DRAM_DW-1:0] dram_wdata,
  output logic [DRAM_MW-1:0] dram_wdata_mask,
  input  logic [DRAM_DW-1:0] dram_rdata,
  input  logic               dram_rdata_valid,
  input  logic               refresh_req,
  output logic               refresh_ack
);

  arb_state_e state_r;
  arb_state_e state_s;
  logic       prio_r;          // 1: s1 wins a tie
  logic       elig0_s;
  logic       elig1_s;
  logic       grant0_s;
  logic       grant1_s;
  logic       accept_s;
  logic       push_s;
  logic       pop_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic       fifo_head_s;
  logic       refresh_ack_s;

  // Eligibility and round-robin grant
  always_comb begin
    elig0_s  = (state_r == IDLE) && s0_valid && !refresh_req && (s0_write || !fifo_full_s);
    elig1_s  = (state_r == IDLE) && s1_valid && !refresh_req && (s1_write || !fifo_full_s);
    grant0_s = elig0_s && (!elig1_s || !prio_r);
    grant1_s = elig1_s && (!elig0_s || prio_r);
  end

  assign s0_ready = grant0_s && !reset;
  assign s1_ready = grant1_s && !reset;
  assign accept_s = (grant0_s || grant1_s) && !reset;
  assign push_s   = accept_s && !(grant1_s ? s1_write : s0_write);

  // Returned beats go to whoever issued the oldest outstanding read; beats with no owner are dropped
  assign pop_s          = dram_rdata_valid && !fifo_empty_s;
  assign s0_rdata_valid = pop_s && !fifo_head_s;
  assign s1_rdata_valid = pop_s && fifo_head_s;
  assign s0_rdata       = dram_rdata;
  assign s1_rdata       = dram_rdata;

  ip_dram_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .AW    (TAG_AW)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .push_tag (grant1_s),
    .pop      (pop_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .head     (fifo_head_s)
  );

  // Next-state logic; refresh is only acknowledged once every issued read has returned
  always_comb begin
    state_s       = state_r;
    refresh_ack_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (refresh_req) begin
          state_s = REFRESH;
        end else if (accept_s) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (dram_ready) begin
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      REFRESH: begin
        if (!refresh_req) begin
          state_s = IDLE;
        end else begin
          state_s       = REFRESH;
          refresh_ack_s = fifo_empty_s;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control registers: state, priority pointer, handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      prio_r      <= 1'b0;
      dram_valid  <= 1'b0;
      refresh_ack <= 1'b0;
    end else begin
      state_r     <= state_s;
      dram_valid  <= (state_s == BUSY);
      refresh_ack <= refresh_ack_s;
      if (accept_s) begin
        prio_r <= grant0_s;
      end
    end
  end

  // Request capture; held untouched while BUSY so the command is stable until dram_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dram_address    <= '0;
      dram_write      <= 1'b0;
      dram_wdata      <= '0;
      dram_wdata_mask <= '0;
    end else if (accept_s) begin
      dram_address    <= grant1_s ? s1_address    : s0_address;
      dram_write      <= grant1_s ? s1_write      : s0_write;
      dram_wdata      <= grant1_s ? s1_wdata      : s0_wdata;
      dram_wdata_mask <= grant1_s ? s1_wdata_mask : s0_wdata_mask;
    end
  end

endmodule
